fifo_uart_tx: RTL and testbench

Drain stage that sits directly downstream of the 8-bit synchronous FIFO. It pops bytes from the FIFO one at a time and serialises each as an asynchronous 8N1 UART frame on a single output line. The FIFO's `wr_en`/`in` side stays with the producer. This block owns the FIFO's `rd_en` and consumes `out` and `empty`.

---
 rtl/fifo_uart_pkg.sv | 17 +
 rtl/fifo_uart_tx_baud.sv | 26 ++
 rtl/fifo_uart_tx.sv | 95 +++++++++
 tb/tb_fifo_uart_tx.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period timer: tick is high on the last clock of each serial bit period.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int             CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    assign tick = run && (cnt_q == LAST);

    // Count 0..CLKS_PER_BIT-1, wrapping on tick so each new bit period starts at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               cnt_q <= '0;
        else if (clear || tick) cnt_q <= '0;
        else if (run)           cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a synchronous FIFO and serialises each one as an 8N1 UART frame.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_data,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] bytes_sent
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_q, bit_d;
    logic                 tx_d, rd_d;
    logic [CNT_W-1:0]     bs_q;
    logic                 tick, run;

    // The bit timer only runs while a frame is on the line; it rests at zero
    // elsewhere and wraps on every tick, so it is zero on entry to START/DATA/STOP.
    assign run = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

    baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (!run),
        .run   (run),
        .tick  (tick)
    );

    assign busy       = (state_q != ST_IDLE);
    assign bytes_sent = bs_q;

    // Next-state, shift register and registered-output logic.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        unique case (state_q)
            ST_IDLE:  if (enable && !fifo_empty) state_d = ST_POP;
            ST_POP:   state_d = ST_LOAD;
            ST_LOAD: begin
                shift_d = fifo_data;
                state_d = ST_START;
            end
            ST_START: if (tick) begin
                state_d = ST_DATA;
                bit_d   = '0;
            end
            ST_DATA: if (tick) begin
                shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                if (bit_q == LAST_BIT) state_d = ST_STOP;
                else                   bit_d   = bit_q + 3'd1;
            end
            ST_STOP: if (tick) state_d = (enable && !fifo_empty) ? ST_POP : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // tx and rd_en are registered from the next state so they change cleanly on the edge.
        rd_d = (state_d == ST_POP);
        case (state_d)
            ST_START: tx_d = START_BIT;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = STOP_BIT;
        endcase
    end

    // State, datapath and output registers; reset drops the in-flight byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_q      <= '0;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            bs_q       <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            tx         <= tx_d;
            fifo_rd_en <= rd_d;
            if (state_q == ST_STOP && tick) bs_q <= bs_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

    localparam int CPB    = 4;
    localparam int FRAME  = 10 * CPB;
    localparam int PERIOD = FRAME + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_rd_en, tx, busy;
    logic [15:0] bytes_sent;

    logic        en2 = 1'b0, empty2 = 1'b1;
    logic [7:0]  data2 = 8'h00;
    logic        rd2, tx2, busy2;
    logic [1:0]  bs2;

    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;

    int errors = 0;
    int checks = 0;
    int exp_bs = 0;
    int rd_empty_err = 0;
    int cyc_n = 0;
    int rd2_cnt = 0;

    logic [7:0]  fq[$];
    logic [7:0]  expq[$];
    logic        txl[$], busyl[$], el[$], rdl[$];
    logic [15:0] bsl[$];
    logic [7:0]  rx_bytes[$];
    int          rx_start[$];
    logic        rx_ok[$];
    logic [1:0]  bs2_vals[$];
    int          bs2_cyc[$];
    logic [1:0]  bs2_prev = 2'd0;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .bytes_sent(bytes_sent));

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .enable(en2), .fifo_empty(empty2), .fifo_data(data2),
        .fifo_rd_en(rd2), .tx(tx2), .busy(busy2), .bytes_sent(bs2));

    always #5 clk = ~clk;

    // Behavioural 8-deep synchronous FIFO: data valid the cycle after a read.
    always @(posedge clk) begin
        logic [7:0] tmp;
        cyc_n <= cyc_n + 1;
        if (fifo_rd_en) begin
            if (fq.size() > 0) begin
                tmp = fq.pop_front();
                fifo_data <= tmp;
            end else rd_empty_err <= rd_empty_err + 1;
        end
        if (wr_en && fq.size() < 8) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
    end

    // Line logger and counter-change recorder, sampled on the falling edge.
    always @(negedge clk) begin
        txl.push_back(tx); busyl.push_back(busy); el.push_back(fifo_empty);
        rdl.push_back(fifo_rd_en); bsl.push_back(bytes_sent);
        if (rd2) rd2_cnt <= rd2_cnt + 1;
        if (bs2 !== bs2_prev) begin bs2_vals.push_back(bs2); bs2_cyc.push_back(cyc_n); end
        bs2_prev <= bs2;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_data = d; expq.push_back(d);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Reference receiver: finds each falling start edge, samples mid-bit, and
    // confirms every sample of the frame equals the ideal 8N1 waveform.
    task automatic decode(input int base);
        int i, bi;
        logic [7:0] b;
        logic ok, eb;
        rx_bytes.delete(); rx_start.delete(); rx_ok.delete();
        i = base + 1;
        while (i + FRAME <= txl.size()) begin
            if (txl[i-1] === 1'b1 && txl[i] === 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = txl[i + CPB + k*CPB + CPB/2];
                ok = 1'b1;
                for (int c = 0; c < FRAME; c++) begin
                    bi = c / CPB;
                    eb = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
                    if (txl[i+c] !== eb) ok = 1'b0;
                end
                rx_bytes.push_back(b); rx_start.push_back(i); rx_ok.push_back(ok);
                i = i + FRAME;
            end else i++;
        end
    endtask

    function automatic int rd_pulses(input int base);
        int n = 0;
        for (int i = base; i < rdl.size(); i++) if (rdl[i] === 1'b1) n++;
        return n;
    endfunction

    task automatic test_reset;
        #1 rst = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
        checks++; if (bytes_sent !== 16'd0) begin errors++; $display("FAIL reset_bytes: got %0d want 0", bytes_sent); end
        checks++; if (bs2 !== 2'd0 || tx2 !== 1'b1) begin errors++; $display("FAIL reset_dut2: got bs=%0d tx=%b want 0/1", bs2, tx2); end
        @(negedge clk); rst = 1'b1;
        tick(2);
        exp_bs = 0;
    endtask

    task automatic test_single;
        int base, c, s;
        expq.delete(); enable = 1'b1; base = txl.size();
        push(8'hA5);
        tick(60);
        decode(base);
        checks++;
        if (rx_bytes.size() != 1) begin errors++; $display("FAIL single_count: got %0d frames want 1", rx_bytes.size()); end
        else begin
            s = rx_start[0]; c = -100;
            for (int i = base; i < el.size(); i++) if (el[i] === 1'b0) begin c = i; break; end
            checks++; if (rx_bytes[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", rx_bytes[0]); end
            checks++; if (rx_ok[0] !== 1'b1) begin errors++; $display("FAIL single_wave: frame waveform got bad want exact 8N1"); end
            checks++; if (s != c + 3) begin errors++; $display("FAIL single_latency: got start %0d want %0d", s - c, 3); end
            checks++; if (busyl[s+FRAME-1] !== 1'b1 || busyl[s+FRAME] !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b%b want 10", busyl[s+FRAME-1], busyl[s+FRAME]); end
            checks++; if (bsl[s+FRAME-1] !== 16'(exp_bs) || bsl[s+FRAME] !== 16'(exp_bs + 1)) begin errors++; $display("FAIL single_bytes_edge: got %0d->%0d want %0d->%0d", bsl[s+FRAME-1], bsl[s+FRAME], exp_bs, exp_bs + 1); end
        end
        exp_bs++;
        checks++; if (rd_pulses(base) != 1) begin errors++; $display("FAIL single_rd_pulses: got %0d want 1", rd_pulses(base)); end
        checks++; if (bytes_sent !== 16'(exp_bs)) begin errors++; $display("FAIL single_bytes: got %0d want %0d", bytes_sent, exp_bs); end
    endtask

    task automatic test_burst;
        int base, n;
        logic [7:0] d[$];
        for (int r = 0; r < 2; r++) begin
            d.delete();
            if (r == 0) begin d.push_back(8'd10); d.push_back(8'd20); d.push_back(8'd30); end
            else begin
                n = $urandom_range(2, 7);
                for (int k = 0; k < n; k++) d.push_back(8'($urandom));
            end
            expq.delete(); base = txl.size();
            foreach (d[k]) push(d[k]);
            tick(d.size() * PERIOD + 20);
            decode(base);
            checks++;
            if (rx_bytes.size() != expq.size()) begin errors++; $display("FAIL burst%0d_count: got %0d want %0d", r, rx_bytes.size(), expq.size()); end
            else begin
                foreach (expq[k]) begin
                    checks++; if (rx_bytes[k] !== expq[k] || rx_ok[k] !== 1'b1) begin errors++; $display("FAIL burst%0d_frame%0d: got %h ok=%b want %h", r, k, rx_bytes[k], rx_ok[k], expq[k]); end
                    if (k > 0) begin
                        checks++; if (rx_start[k] - rx_start[k-1] != PERIOD) begin errors++; $display("FAIL burst%0d_gap%0d: got %0d want %0d", r, k, rx_start[k] - rx_start[k-1], PERIOD); end
                    end
                end
            end
            exp_bs += expq.size();
            checks++; if (bytes_sent !== 16'(exp_bs)) begin errors++; $display("FAIL burst%0d_bytes: got %0d want %0d", r, bytes_sent, exp_bs); end
            checks++; if (fifo_empty !== 1'b1 || rd_empty_err != 0) begin errors++; $display("FAIL burst%0d_empty: got empty=%b bad_reads=%0d want 1/0", r, fifo_empty, rd_empty_err); end
        end
    endtask

    task automatic test_enable_gating;
        int base, zeros;
        enable = 1'b0; expq.delete(); base = txl.size();
        for (int k = 0; k < 8; k++) push(8'($urandom));
        tick(100);
        zeros = 0;
        for (int i = base; i < txl.size(); i++) if (txl[i] !== 1'b1) zeros++;
        checks++; if (rd_pulses(base) != 0) begin errors++; $display("FAIL gate_rd: got %0d pulses want 0", rd_pulses(base)); end
        checks++; if (zeros != 0) begin errors++; $display("FAIL gate_tx: got %0d low samples want 0", zeros); end
        checks++; if (fq.size() != 8) begin errors++; $display("FAIL gate_level: got %0d want 8", fq.size()); end
        base = txl.size(); enable = 1'b1;
        tick(8 * PERIOD + 20);
        decode(base);
        checks++;
        if (rx_bytes.size() != 8) begin errors++; $display("FAIL gate_count: got %0d want 8", rx_bytes.size()); end
        else foreach (expq[k]) begin
            checks++; if (rx_bytes[k] !== expq[k] || rx_ok[k] !== 1'b1) begin errors++; $display("FAIL gate_frame%0d: got %h want %h", k, rx_bytes[k], expq[k]); end
        end
        exp_bs += 8;
        checks++; if (bytes_sent !== 16'(exp_bs)) begin errors++; $display("FAIL gate_bytes: got %0d want %0d", bytes_sent, exp_bs); end
    endtask

    task automatic test_enable_drop;
        int base;
        bit seen = 0;
        enable = 1'b0; expq.delete(); base = txl.size();
        push(8'h3C); push(8'h55);
        enable = 1'b1;
        for (int t = 0; t < 20; t++) begin @(negedge clk); if (tx === 1'b0) begin seen = 1; break; end end
        checks++; if (!seen) begin errors++; $display("FAIL drop_start: got no start bit within 20 cycles want start"); end
        repeat (5) @(negedge clk);
        enable = 1'b0;
        tick(60);
        decode(base);
        checks++; if (rx_bytes.size() != 1 || rx_bytes[0] !== 8'h3C || rx_ok[0] !== 1'b1) begin errors++; $display("FAIL drop_frame: got %0d frames want one 3c", rx_bytes.size()); end
        checks++; if (fq.size() != 1) begin errors++; $display("FAIL drop_level: got %0d want 1", fq.size()); end
        checks++; if (rd_pulses(base) != 1) begin errors++; $display("FAIL drop_rd: got %0d want 1", rd_pulses(base)); end
        exp_bs++;
        checks++; if (busy !== 1'b0 || bytes_sent !== 16'(exp_bs)) begin errors++; $display("FAIL drop_idle: got busy=%b bytes=%0d want 0/%0d", busy, bytes_sent, exp_bs); end
        enable = 1'b1;
        tick(PERIOD + 10);
        exp_bs++;
        checks++; if (bytes_sent !== 16'(exp_bs) || fifo_empty !== 1'b1) begin errors++; $display("FAIL drop_drain: got bytes=%0d empty=%b want %0d/1", bytes_sent, fifo_empty, exp_bs); end
    endtask

    task automatic test_reset_mid;
        int base;
        bit seen = 0;
        enable = 1'b1; expq.delete();
        push(8'hFF);
        for (int t = 0; t < 20; t++) begin @(negedge clk); if (tx === 1'b0) begin seen = 1; break; end end
        checks++; if (!seen) begin errors++; $display("FAIL rstmid_start: got no start bit want start"); end
        repeat (21) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy: got %b want 1", busy); end
        #2 rst = 1'b0;
        #1;
        checks++; if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_async: got tx=%b busy=%b rd=%b want 1/0/0", tx, busy, fifo_rd_en); end
        checks++; if (bytes_sent !== 16'd0) begin errors++; $display("FAIL rstmid_bytes: got %0d want 0", bytes_sent); end
        @(negedge clk); rst = 1'b1;
        exp_bs = 0; expq.delete(); base = txl.size();
        push(8'h01);
        tick(PERIOD + 10);
        decode(base);
        checks++; if (rx_bytes.size() != 1 || rx_bytes[0] !== 8'h01 || rx_ok[0] !== 1'b1) begin errors++; $display("FAIL rstmid_next: got %0d frames want one 01", rx_bytes.size()); end
        exp_bs = 1;
        checks++; if (bytes_sent !== 16'(exp_bs) || fq.size() != 0) begin errors++; $display("FAIL rstmid_after: got bytes=%0d level=%0d want 1/0", bytes_sent, fq.size()); end
    endtask

    task automatic test_wrap;
        int vb, rb;
        bit seen = 0;
        vb = bs2_vals.size(); rb = rd2_cnt;
        @(posedge clk); #1;
        data2 = 8'($urandom); empty2 = 1'b0; en2 = 1'b1;
        for (int t = 0; t < 5 * PERIOD + 40; t++) begin
            @(negedge clk); #1;
            if (bs2_vals.size() - vb >= 4) begin seen = 1; break; end
        end
        en2 = 1'b0;
        checks++; if (!seen) begin errors++; $display("FAIL wrap_progress: got %0d updates want 4", bs2_vals.size() - vb); end
        tick(PERIOD + 20);
        empty2 = 1'b1;
        checks++;
        if (bs2_vals.size() - vb != 5) begin errors++; $display("FAIL wrap_count: got %0d updates want 5", bs2_vals.size() - vb); end
        else for (int k = 0; k < 5; k++) begin
            checks++; if (bs2_vals[vb+k] !== 2'((k + 1) % 4)) begin errors++; $display("FAIL wrap_value%0d: got %0d want %0d", k, bs2_vals[vb+k], (k + 1) % 4); end
            if (k > 0) begin
                checks++; if (bs2_cyc[vb+k] - bs2_cyc[vb+k-1] != PERIOD) begin errors++; $display("FAIL wrap_period%0d: got %0d want %0d", k, bs2_cyc[vb+k] - bs2_cyc[vb+k-1], PERIOD); end
            end
        end
        checks++; if (rd2_cnt - rb != 5 || busy2 !== 1'b0) begin errors++; $display("FAIL wrap_pops: got %0d busy=%b want 5/0", rd2_cnt - rb, busy2); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_burst;
        test_enable_gating;
        test_enable_drop;
        test_reset_mid;
        test_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
